mul_controller: RTL and testbench

Control FSM for the repeated-addition multiplier datapath. It sequences operand loading from the shared 16-bit input bus, runs the add/decrement loop until the datapath reports a zero counter, and signals completion. It sits directly upstream of the datapath: it drives `LdA`, `LdB`, `LdP`, `clrP` and `decB`, and consumes `eqz`. It adds a valid/ready operand handshake, abort, and an iteration count for performance checks.

---
 rtl/mul_pkg.sv | 25 ++
 rtl/mul_controller_sat_cntr.sv | 31 +++
 rtl/mul_controller.sv | 130 +++++++++++++
 tb/tb_mul_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_pkg                                                              |
// | Shared types and constants for the repeated-addition multiplier.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mul_pkg;

  // Datapath operand / product width
  localparam int MUL_DW = 16;

  // Default iteration counter width: holds 2^16-1 additions without saturating
  localparam int MUL_CW = 17;

  // Controller state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_ADD    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mul_controller_sat_cntr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_cntr                                                             |
// | Saturating up-counter with synchronous clear and count enable.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_cntr #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/mul_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mul_controller                                                       |
// | Control FSM for the repeated-addition multiplier: operand loading    |
// | with valid/ready, add/decrement loop until eqz, done pulse, abort.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mul_controller
  import mul_pkg::*;
#(
  parameter int CW = MUL_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          eqz,
  output logic          LdA,
  output logic          LdB,
  output logic          LdP,
  output logic          clrP,
  output logic          decB,
  output logic          busy,
  output logic          done,
  output logic          res_valid,
  output logic [CW-1:0] iter_cnt
);

  state_e state_q, state_d;
  logic   res_valid_q;
  logic   start_acc;
  logic   cnt_en;

  // Next-state and datapath control decode; controls act on the same edge
  // that advances the FSM, so they are purely combinational here
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    LdA       = 1'b0;
    LdB       = 1'b0;
    LdP       = 1'b0;
    clrP      = 1'b0;
    decB      = 1'b0;
    start_acc = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        in_ready = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          LdA     = 1'b1;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        in_ready = 1'b1;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (in_valid) begin
          // B load and P clear share the handshake cycle
          LdB     = 1'b1;
          clrP    = 1'b1;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (eqz) begin
          state_d = ST_DONE;
        end else begin
          LdP    = 1'b1;
          decB   = 1'b1;
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result-valid flag: set on entry to DONE (visible alongside done), cleared by a new start
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
    end else if (start_acc) begin
      res_valid_q <= 1'b0;
    end else if (state_d == ST_DONE) begin
      res_valid_q <= 1'b1;
    end
  end

  sat_cntr #(
    .W (CW)
  ) u_iter_cntr (
    .clk (clk),
    .rst (rst),
    .clr (start_acc),
    .en  (cnt_en),
    .cnt (iter_cnt)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign res_valid = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mul_controller                                                    |
// | Self-checking bench: controller plus a behavioural datapath, checked |
// | against product/iteration/latency expectations from A*B arithmetic.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mul_controller;

  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          eqz;
  logic          LdA, LdB, LdP, clrP, decB;
  logic          busy, done, res_valid;
  logic [CW-1:0] iter_cnt;
  logic [15:0]   data_in = '0;

  // Behavioural datapath
  logic [15:0]   ra = '0, rb = '0, rp = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (LdA) ra <= data_in;
    if (LdB) rb <= data_in;
    else if (decB) rb <= rb - 16'd1;
    if (clrP) rp <= '0;
    else if (LdP) rp <= rp + ra;
  end

  assign eqz = (rb == 16'd0);

  mul_controller #(.CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .eqz       (eqz),
    .LdA       (LdA),
    .LdB       (LdB),
    .LdP       (LdP),
    .clrP      (clrP),
    .decB      (decB),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .iter_cnt  (iter_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
    chk({tag, "_ctl"},       32'({LdA, LdB, LdP, clrP, decB}), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_iter_cnt"},  32'(iter_cnt),  32'd0);
  endtask

  // Start an operation and deliver A then B, with ga/gb idle cycles before each handshake.
  // Returns one cycle after the B handshake (first ADD cycle).
  task automatic load_ops(input logic [15:0] a, input logic [15:0] b, input int ga, input int gb);
    start = 1'b1; abort = 1'b0; in_valid = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    tick();
    start = 1'b0;
    for (int g = 0; g < ga; g++) begin
      in_valid = 1'b0; data_in = 16'($urandom);
      #1;
      chk("lda_gap", 32'(LdA), 32'd0);
      chk("ready_a", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b1; data_in = a;
    #1;
    chk("lda_hs", 32'(LdA), 32'd1);
    tick();
    for (int g = 0; g < gb; g++) begin
      in_valid = 1'b0; data_in = 16'($urandom);
      #1;
      chk("ldb_gap", 32'({LdB, clrP}), 32'd0);
      chk("ready_b", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b1; data_in = b;
    #1;
    chk("ldb_clrp_hs", 32'({LdB, clrP}), 32'd3);
    tick();
    in_valid = 1'b0;
  endtask

  // Run the ADD phase. rel counts cycles after the B handshake.
  task automatic run_add(input logic [15:0] a, input logic [15:0] b, input int abort_rel,
                         input int rst_rel, input logic rand_start);
    int bi = int'(b);
    int ldp = 0;
    int dn = 0;
    int done_rel = -1;
    for (int rel = 1; rel <= bi + 3; rel++) begin
      start = (rand_start && rel <= bi + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (rel == abort_rel);
      rst   = (rel == rst_rel);
      #1;
      if (LdP) ldp++;
      if (done) begin dn++; done_rel = rel; end
      if (rel == abort_rel) begin
        chk("abort_ctl_forced", 32'({LdP, decB}), 32'd0);
      end
      tick();
      if (rel == abort_rel || rel == rst_rel) begin
        abort = 1'b0; rst = 1'b0; start = 1'b0;
        #1;
        if (rel == abort_rel) begin
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_done", 32'(dn + int'(done)), 32'd0);
          chk("abort_res_valid", 32'(res_valid), 32'd0);
        end else begin
          chk_reset_outputs("rst_mid_add");
        end
        tick();
        return;
      end
    end
    start = 1'b0;
    #1;
    chk("ldp_count", 32'(ldp), 32'(bi));
    chk("done_count", 32'(dn), 32'd1);
    chk("done_latency", 32'(done_rel), 32'(bi + 2));
    chk("product", 32'(rp), 32'(16'(a * b)));
    chk("iter_cnt", 32'(iter_cnt), 32'(bi));
    chk("res_valid_after", 32'(res_valid), 32'd1);
    chk("idle_after", 32'({busy, done}), 32'd0);
    tick();
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          ga;
    int          gb;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{a: 16'd7,   b: 16'd5,   ga: 0, gb: 0, p: 16'd35};
    vecs[1] = '{a: 16'd9,   b: 16'd0,   ga: 0, gb: 0, p: 16'd0};
    vecs[2] = '{a: 16'd0,   b: 16'd3,   ga: 0, gb: 0, p: 16'd0};
    vecs[3] = '{a: 16'd300, b: 16'd300, ga: 0, gb: 0, p: 16'h5F90};
    vecs[4] = '{a: 16'd4,   b: 16'd6,   ga: 3, gb: 2, p: 16'd24};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk_reset_outputs("reset");
    tick();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      load_ops(vecs[i].a, vecs[i].b, vecs[i].ga, vecs[i].gb);
      run_add(vecs[i].a, vecs[i].b, -1, -1, 1'b0);
      chk("table_product", 32'(rp), 32'(vecs[i].p));
    end

    // Abort in the 3rd ADD cycle, then a clean op
    load_ops(16'd5, 16'd10, 0, 0);
    run_add(16'd5, 16'd10, 3, -1, 1'b0);
    load_ops(16'd2, 16'd3, 0, 0);
    run_add(16'd2, 16'd3, -1, -1, 1'b0);

    // Randomized ops with stray start pulses while busy
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom_range(0, 20));
      load_ops(a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_add(a, b, -1, -1, 1'b1);
    end

    // Reset mid-ADD, then a clean op
    load_ops(16'd5, 16'd10, 0, 0);
    run_add(16'd5, 16'd10, -1, 4, 1'b1);
    load_ops(16'd2, 16'd3, 1, 1);
    run_add(16'd2, 16'd3, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
